// File: rtl/wb_shared_bus.sv
// Wishbone shared-bus interconnect: N masters share one slave-side bus.
// Round-robin arbiter (grant_o is the arbiter state: 0 = idle, one-hot =
// owner), mask/base address decode with lowest-index priority, error
// termination for unmapped addresses and a watchdog for hung slaves.
//
// Handshake: a master owns a transfer while cyc and stb are high; the
// transfer completes in the cycle the routed slave (or the interconnect
// itself) returns ack, err or rty. cyc held high keeps bus ownership across
// multiple transfers and bursts.
module wb_shared_bus #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned ADDR_WIDTH     = 23,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {23'h000000, 23'h000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {23'h7FFFF8, 23'h000000},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_MASTERS-1:0]           wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]           wbm_stb_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS-1:0]           wbm_we_i,
  input  logic [NUM_MASTERS-1:0]           wbm_sel_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*3-1:0]         wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]         wbm_bte_i,
  output logic [NUM_MASTERS-1:0]           wbm_ack_o,
  output logic [NUM_MASTERS-1:0]           wbm_err_o,
  output logic [NUM_MASTERS-1:0]           wbm_rty_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_o,
  output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]            wbs_stb_o,
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic                             wbs_we_o,
  output logic                             wbs_sel_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic [2:0]                       wbs_cti_o,
  output logic [1:0]                       wbs_bte_o,
  input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]            wbs_err_i,
  input  logic [NUM_SLAVES-1:0]            wbs_rty_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
  output logic [NUM_MASTERS-1:0]           grant_o
);

  localparam int MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry fires in the cycle the count would reach TIMEOUT_CYCLES.
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WDW'(TIMEOUT_CYCLES - 1) : '0;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          last_q, last_d;
  logic [WDW-1:0]         wdog_q, wdog_d;
  logic                   pend_q, pend_d;

  logic                   owned;
  logic [MW-1:0]          owner;
  logic                   o_cyc, o_stb, o_we, o_sel;
  logic [ADDR_WIDTH-1:0]  o_adr;
  logic [DATA_WIDTH-1:0]  o_dat;
  logic [2:0]             o_cti;
  logic [1:0]             o_bte;
  logic [NUM_SLAVES-1:0]  hit;
  logic                   any_hit;
  logic                   s_ack, s_err, s_rty;
  logic [DATA_WIDTH-1:0]  s_dat;
  logic                   waiting, expire, miss;
  int                     base, tgt;
  logic                   found;

  // Select the owning master's request signals (all zero when idle).
  always_comb begin
    owned = |grant_q;
    owner = '0;
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we  = 1'b0;
    o_sel = 1'b0;
    o_adr = '0;
    o_dat = '0;
    o_cti = '0;
    o_bte = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (grant_q[m]) begin
        owner = MW'(m);
        o_cyc = wbm_cyc_i[m];
        o_stb = wbm_stb_i[m];
        o_we  = wbm_we_i[m];
        o_sel = wbm_sel_i[m];
        o_adr = wbm_adr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
        o_dat = wbm_dat_i[m*DATA_WIDTH +: DATA_WIDTH];
        o_cti = wbm_cti_i[m*3 +: 3];
        o_bte = wbm_bte_i[m*2 +: 2];
      end
    end
  end

  // Address decode and response pick-up from the single hit slave.
  always_comb begin
    hit     = '0;
    any_hit = 1'b0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rty   = 1'b0;
    s_dat   = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (!any_hit && ((o_adr & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) ==
                       SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit[s]  = 1'b1;
        any_hit = 1'b1;
      end
    end
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (hit[s] && o_cyc) begin
        s_ack = wbs_ack_i[s];
        s_err = wbs_err_i[s];
        s_rty = wbs_rty_i[s];
        s_dat = wbs_dat_i[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    waiting = o_cyc && o_stb && any_hit && !(s_ack || s_err || s_rty);
    expire  = (TIMEOUT_CYCLES > 0) && waiting && (wdog_q == WD_LAST);
    miss    = o_cyc && o_stb && !any_hit;
  end

  // Drive slave-side shared bus and route the response to the owner only.
  always_comb begin
    wbs_cyc_o = (o_cyc && !expire) ? hit : '0;
    wbs_stb_o = (o_stb && !expire) ? hit : '0;
    wbs_adr_o = o_adr;
    wbs_we_o  = o_we;
    wbs_sel_o = o_sel;
    wbs_dat_o = o_dat;
    wbs_cti_o = o_cti;
    wbs_bte_o = o_bte;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    wbm_dat_o = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (grant_q[m]) begin
        wbm_ack_o[m] = s_ack;
        wbm_err_o[m] = s_err || pend_q || expire;
        wbm_rty_o[m] = s_rty;
        wbm_dat_o[m*DATA_WIDTH +: DATA_WIDTH] = s_dat;
      end
    end
    grant_o = grant_q;
  end

  // Round-robin decision when idle or when the owner drops cyc; the search
  // starts one past the most recent owner so handover has no idle cycle.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    base    = int'(last_q);
    tgt     = 0;
    found   = 1'b0;
    if (!owned || !o_cyc) begin
      if (owned) begin
        last_d = owner;
        base   = int'(owner);
      end
      grant_d = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        tgt = base + k;
        if (tgt >= NUM_MASTERS) tgt = tgt - NUM_MASTERS;
        for (int m = 0; m < NUM_MASTERS; m++) begin
          if (!found && (m == tgt) && wbm_cyc_i[m]) begin
            grant_d[m] = 1'b1;
            found      = 1'b1;
          end
        end
      end
    end
  end

  // Watchdog counts unanswered strobe cycles; decode-miss error is delayed
  // one cycle and cannot re-arm while it is being driven.
  always_comb begin
    if (!waiting || expire) wdog_d = '0;
    else                    wdog_d = wdog_q + WDW'(1);
    pend_d = miss && !pend_q;
  end

  // Arbiter, watchdog and error-flag state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= '0;
      last_q  <= MW'(NUM_MASTERS - 1);
      wdog_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus: two masters, two slaves,
// slave 0 = 0x000000..0x000007, slave 1 = 0x000100..0x0001FF, watchdog 4.
module tb_wb_shared_bus;

  logic        clk, rst_n;
  logic [1:0]  m_cyc, m_stb, m_we, m_sel;
  logic [45:0] m_adr;
  logic [15:0] m_dat;
  logic [5:0]  m_cti;
  logic [3:0]  m_bte;
  logic [1:0]  m_ack, m_err, m_rty;
  logic [15:0] m_rdat;
  logic [1:0]  s_cyc, s_stb;
  logic [22:0] s_adr;
  logic        s_we, s_sel;
  logic [7:0]  s_wdat;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  s_ack, s_err, s_rty;
  logic [15:0] s_rdat;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  wb_shared_bus #(
    .NUM_MASTERS(2), .NUM_SLAVES(2), .ADDR_WIDTH(23), .DATA_WIDTH(8),
    .SLAVE_BASE({23'h000100, 23'h000000}),
    .SLAVE_MASK({23'h7FFF00, 23'h7FFFF8}),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_adr_i(m_adr), .wbm_we_i(m_we),
    .wbm_sel_i(m_sel), .wbm_dat_i(m_dat), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty), .wbm_dat_o(m_rdat),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_adr_o(s_adr), .wbs_we_o(s_we),
    .wbs_sel_o(s_sel), .wbs_dat_o(s_wdat), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty), .wbs_dat_i(s_rdat),
    .grant_o(grant)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout got running exp finished");
    $fatal(1);
  end

  // Inputs change on the falling edge; outputs are checked 1 ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    m_cti = '0; m_bte = '0; s_ack = '0; s_err = '0; s_rty = '0; s_rdat = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    #1;
    checks++;
    if ({grant, s_cyc, s_stb, m_ack, m_err, m_rty} !== 12'h000) begin
      errors++; $display("FAIL reset_ctrl got %h exp 000", {grant, s_cyc, s_stb, m_ack, m_err, m_rty});
    end
    checks++;
    if ({s_adr, s_wdat, m_rdat} !== 47'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {s_adr, s_wdat, m_rdat});
    end
    step();
    rst_n = 1'b1;
  endtask

  // Master 0 reads 0x000005 from slave 0, ack with 0xA5 on the third owned cycle.
  task automatic test_single_read();
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[22:0] = 23'h000005;
    #1;
    checks++;
    if ({grant, s_cyc} !== 4'b0000) begin
      errors++; $display("FAIL t1_latency got %b exp 0000", {grant, s_cyc});
    end
    step(); #1;
    checks++;
    if ({grant, s_cyc, s_stb} !== 6'b01_01_01) begin
      errors++; $display("FAIL t1_route got %b exp 010101", {grant, s_cyc, s_stb});
    end
    checks++;
    if (s_adr !== 23'h000005 || m_ack !== 2'b00) begin
      errors++; $display("FAIL t1_adr got %h/%b exp 000005/00", s_adr, m_ack);
    end
    step(); #1;
    checks++;
    if (m_ack !== 2'b00) begin
      errors++; $display("FAIL t1_noack got %b exp 00", m_ack);
    end
    step();
    s_ack = 2'b01; s_rdat = 16'h00A5;
    #1;
    checks++;
    if ({m_ack, m_err, m_rdat} !== {2'b01, 2'b00, 16'h00A5}) begin
      errors++; $display("FAIL t1_ack got %b %b %h exp 01 00 00a5", m_ack, m_err, m_rdat);
    end
    checks++;
    if (s_cyc[1] !== 1'b0) begin
      errors++; $display("FAIL t1_s1_idle got %b exp 0", s_cyc[1]);
    end
    step();
    clear_inputs();
    step(); #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL t1_release got %b exp 00", grant);
    end
  endtask

  // Simultaneous requests from reset alternate 0,1,0,1 with zero-gap handover.
  task automatic test_round_robin();
    logic [1:0] exp_g [0:5];
    logic [1:0] drive [0:5];
    exp_g = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
    drive = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b10, 2'b00};
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      m_cyc = drive[i];
      #1;
      checks++;
      if (grant !== exp_g[i]) begin
        errors++; $display("FAIL t2_grant[%0d] got %b exp %b", i, grant, exp_g[i]);
      end
    end
    step(); #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL t2_idle got %b exp 00", grant);
    end
  endtask

  // Master 1 keeps a 4-beat burst while master 0 waits.
  task automatic test_burst_hold();
    step();
    m_cyc = 2'b10;
    step(); #1;
    checks++;
    if (grant !== 2'b10) begin
      errors++; $display("FAIL t3_grant1 got %b exp 10", grant);
    end
    for (int b = 0; b < 4; b++) begin
      step();
      m_cyc = 2'b11; m_stb = 2'b10;
      m_adr[45:23] = 23'h000100 + 23'(b);
      m_cti[5:3] = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 2'b10; s_rdat = {8'h10 + 8'(b), 8'h00};
      #1;
      checks++;
      if ({grant, s_cyc, m_ack} !== 6'b10_10_10 || s_cti !== ((b == 3) ? 3'b111 : 3'b010)) begin
        errors++; $display("FAIL t3_beat[%0d] got %b cti %b exp 101010 cti %b", b, {grant, s_cyc, m_ack}, s_cti, (b == 3) ? 3'b111 : 3'b010);
      end
      checks++;
      if (m_rdat !== {8'h10 + 8'(b), 8'h00} || s_adr !== 23'h000100 + 23'(b)) begin
        errors++; $display("FAIL t3_data[%0d] got %h adr %h", b, m_rdat, s_adr);
      end
    end
    step();
    m_cyc = 2'b01; m_stb = 2'b00; m_cti = '0; s_ack = '0; s_rdat = '0;
    #1;
    checks++;
    if ({grant, m_ack} !== 4'b10_00) begin
      errors++; $display("FAIL t3_hold got %b exp 1000", {grant, m_ack});
    end
    step(); #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL t3_handover got %b exp 01", grant);
    end
  endtask

  // Master 0 (already owner) strobes an unmapped address.
  task automatic test_decode_miss();
    logic [1:0] exp_e [0:3];
    exp_e = '{2'b00, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin m_stb[0] = 1'b1; m_adr[22:0] = 23'h400000; end
      if (i == 2) m_stb[0] = 1'b0;
      #1;
      checks++;
      if ({m_err, s_cyc, s_stb} !== {exp_e[i], 4'b0000}) begin
        errors++; $display("FAIL t4_miss[%0d] got %b exp %b0000", i, {m_err, s_cyc, s_stb}, exp_e[i]);
      end
    end
    step();
    m_cyc = 2'b00;
    step(); #1;
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL t4_release got %b exp 00", grant);
    end
  endtask

  // Slave 1 silent: error on the 4th strobe cycle; then an ack on the 4th wins.
  task automatic test_watchdog();
    step();
    m_cyc = 2'b01; m_adr[22:0] = 23'h000100;
    step(); #1;
    checks++;
    if ({grant, s_cyc} !== 4'b01_10) begin
      errors++; $display("FAIL t5_grant got %b exp 0110", {grant, s_cyc});
    end
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      m_stb[0] = 1'b1;
      #1;
      checks++;
      if ({m_err, s_cyc, s_stb} !== ((c == 4) ? 6'b01_00_00 : 6'b00_10_10)) begin
        errors++; $display("FAIL t5_to[%0d] got %b exp %b", c, {m_err, s_cyc, s_stb}, (c == 4) ? 6'b01_00_00 : 6'b00_10_10);
      end
    end
    step();
    m_stb[0] = 1'b0;
    #1;
    checks++;
    if ({m_err, s_cyc, s_stb} !== 6'b00_10_00) begin
      errors++; $display("FAIL t5_after got %b exp 001000", {m_err, s_cyc, s_stb});
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      m_stb[0] = 1'b1;
      if (c == 4) begin s_ack = 2'b10; s_rdat = 16'h3C00; end
      #1;
      checks++;
      if ({m_ack, m_err, s_cyc} !== ((c == 4) ? 6'b01_00_10 : 6'b00_00_10)) begin
        errors++; $display("FAIL t5_ack[%0d] got %b exp %b", c, {m_ack, m_err, s_cyc}, (c == 4) ? 6'b01_00_10 : 6'b00_00_10);
      end
    end
    checks++;
    if (m_rdat !== 16'h003C) begin
      errors++; $display("FAIL t5_data got %h exp 003c", m_rdat);
    end
    step();
    clear_inputs();
    step();
  endtask

  // Reset while master 1 is mid-burst; pointer must restart at master 0.
  task automatic test_reset_mid();
    step();
    m_cyc = 2'b10; m_stb = 2'b10; m_adr[45:23] = 23'h000100; m_cti[5:3] = 3'b010;
    s_ack = 2'b10; s_rdat = 16'h7700;
    step(); #1;
    checks++;
    if ({grant, m_ack} !== 4'b10_10) begin
      errors++; $display("FAIL t6_pre got %b exp 1010", {grant, m_ack});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, s_cyc, s_stb, m_ack, m_err, m_rty} !== 12'h000 || {s_adr, s_cti, m_rdat} !== 42'h0) begin
      errors++; $display("FAIL t6_async got %b %h exp 0", {grant, s_cyc, s_stb, m_ack, m_err, m_rty}, {s_adr, s_cti, m_rdat});
    end
    m_cyc = 2'b11;
    step();
    rst_n = 1'b1;
    step(); #1;
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL t6_regrant got %b exp 01", grant);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_hold();
    test_decode_miss();
    test_watchdog();
    test_reset_mid();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_shared_bus.md
Name: wb_shared_bus

Overview:
Parametrised Wishbone shared-bus interconnect: NUM_MASTERS masters, NUM_SLAVES slaves, round-robin arbitration, mask/base address decode, and a bus-watchdog timeout. It generalises the fixed 2-master/2-slave interconnect between the SPI bridge, the levenshtein controller and the SRAM controller. It adds fair arbitration, error termination for unmapped addresses, and error termination for hung slaves.

Parameters:
NUM_MASTERS, 2, number of master ports (1..8)
NUM_SLAVES, 2, number of slave ports (1..8)
ADDR_WIDTH, 23, address width
DATA_WIDTH, 8, data width
SLAVE_BASE, {23'h000000, 23'h000000}, packed NUM_SLAVES*ADDR_WIDTH base addresses; slice i belongs to slave i
SLAVE_MASK, {23'h7FFFF8, 23'h000000}, packed decode masks; slave i hits when (adr & MASK_i) == BASE_i; the lowest index wins on overlap
TIMEOUT_CYCLES, 255, watchdog limit in cycles; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wbm_cyc_i  in  NUM_MASTERS  master cycle
wbm_stb_i  in  NUM_MASTERS  master strobe
wbm_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master address
wbm_we_i  in  NUM_MASTERS  master write enable
wbm_sel_i  in  NUM_MASTERS  master byte select
wbm_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data
wbm_cti_i  in  NUM_MASTERS*3  cycle type
wbm_bte_i  in  NUM_MASTERS*2  burst type
wbm_ack_o  out  NUM_MASTERS  acknowledge
wbm_err_o  out  NUM_MASTERS  error
wbm_rty_o  out  NUM_MASTERS  retry
wbm_dat_o  out  NUM_MASTERS*DATA_WIDTH  read data
wbs_cyc_o  out  NUM_SLAVES  per-slave cycle
wbs_stb_o  out  NUM_SLAVES  per-slave strobe
wbs_adr_o  out  ADDR_WIDTH  shared address
wbs_we_o  out  1  shared write enable
wbs_sel_o  out  1  shared byte select
wbs_dat_o  out  DATA_WIDTH  shared write data
wbs_cti_o  out  3  shared cycle type
wbs_bte_o  out  2  shared burst type
wbs_ack_i  in  NUM_SLAVES  slave acknowledge
wbs_err_i  in  NUM_SLAVES  slave error
wbs_rty_i  in  NUM_SLAVES  slave retry
wbs_dat_i  in  NUM_SLAVES*DATA_WIDTH  slave read data
grant_o  out  NUM_MASTERS  one-hot current owner (debug)

Behaviour:
- Reset (rst_ni low, asynchronous): grant_o=0, last-owner pointer=NUM_MASTERS-1, watchdog=0, pending error flag=0.
- Reset effect on outputs: all wbs_cyc_o/stb_o=0 and all wbm_ack_o/err_o/rty_o=0. Shared wbs_* buses and wbm_dat_o=0.
- A reset mid-transaction aborts it silently.
- Arbiter states:
  - IDLE (grant_o=0): at each edge, if any wbm_cyc_i is high, grant the first requester searching from (last owner+1) modulo NUM_MASTERS. The grant becomes visible the next cycle, so arbitration latency is 1 cycle.
  - OWNED: grant is held while the owner's cyc is high. Bursts and multi-access cycles are never preempted.
  - Release: at the edge where the owner's cyc is low, the last-owner pointer becomes the owner and a new round-robin decision is taken from the current requests in the same edge. Handover is back-to-back, with zero idle cycles.
- Routing while OWNED (combinational):
  - The owner's adr/we/sel/dat/cti/bte drive the shared wbs_* buses.
  - wbs_cyc_o[s] = owner cyc & hit[s]; wbs_stb_o[s] = owner stb & hit[s].
  - The owner's ack/err/rty/dat come from the hit slave. Non-owners see ack/err/rty=0 and dat=0.
  - Shared buses read 0 when there is no owner.
- Decode miss (owner cyc&stb, no slave hits):
  - No slave is strobed.
  - wbm_err_o of the owner pulses for exactly 1 cycle, 1 cycle after the strobe is seen.
  - The pending flag blocks a second pulse in the cycle the error is high.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments each cycle the owner has stb high on a hit slave with no ack/err/rty.
  - It clears on any response, on stb low, or on a grant change.
  - When the count reaches TIMEOUT_CYCLES: the owner gets a 1-cycle wbm_err_o, and the hit slave's cyc/stb are forced low for that cycle. The counter then clears.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- A slave response arriving in the same cycle as a watchdog expiry takes priority; no error is generated.
- Slave ack/err/rty on non-selected slaves are ignored.

Test Plan:
1. Single master 0 reads adr 0x000005 (hits slave 0); slave 0 acks with data 0xA5 after 2 cycles -> wbm_dat_o[0]=0xA5 with ack; grant_o=01 from cycle 1; wbs_cyc_o[1] stays 0.
2. Both masters raise cyc in the same cycle out of reset -> master 0 granted first. After master 0 drops cyc, master 1 is granted on the next edge with no idle cycle. Repeat the simultaneous request -> order alternates 0,1,0,1.
3. Master 1 holds cyc across a 4-beat burst (cti=010 then 111) while master 0 requests -> master 0 is not granted until master 1 drops cyc.
4. With both slave masks changed so that 0x400000 matches neither slave, master 0 accesses 0x400000 -> exactly one err pulse on wbm_err_o[0] 1 cycle after stb; wbs_stb_o=00 throughout.
5. TIMEOUT_CYCLES=4; slave 1 never responds -> wbm_err_o pulses at cycle 4 of stb and wbs_cyc_o[1]=0 that cycle. Second run: slave acks at cycle 4 -> ack delivered, no err.
6. Drop rst_ni mid-burst -> all outputs 0 immediately. After release, the arbiter grants from master 0.
